// File: rtl/byte_read_serializer.sv
// byte_read_serializer
//   Captures a SIZE_IN_BYTES-wide word in one cycle and streams it out one
//   byte per transfer, byte 0 (bits 7:0) first, over a valid/ready handshake.
//   The byte index travels with each byte so a downstream byte_write_register
//   can rebuild the word directly.
//
// Ports
//   CLK           clock, rising edge
//   ARESET        asynchronous reset, active low
//   LOAD          capture request (accepted only in IDLE)
//   INPUT_VALUE   word to serialize
//   LOAD_READY    high in IDLE
//   OUTPUT_VALUE  current byte (registered)
//   BYTE_NUM      index of current byte (registered)
//   OUTPUT_VALID  byte/index valid (high in SEND)
//   OUTPUT_READY  downstream accepts the byte
//   LAST          high with OUTPUT_VALID on the final byte
//   DONE          one-cycle pulse after the final byte transfers
module byte_read_serializer #(
  parameter int SIZE_IN_BYTES = 13,
  parameter int BYTE_NUM_SIZE = 4
) (
  input  logic                       CLK,
  input  logic                       ARESET,
  input  logic                       LOAD,
  input  logic [SIZE_IN_BYTES*8-1:0] INPUT_VALUE,
  output logic                       LOAD_READY,
  output logic [7:0]                 OUTPUT_VALUE,
  output logic [BYTE_NUM_SIZE-1:0]   BYTE_NUM,
  output logic                       OUTPUT_VALID,
  input  logic                       OUTPUT_READY,
  output logic                       LAST,
  output logic                       DONE
);

  localparam int W = SIZE_IN_BYTES * 8;
  localparam logic [BYTE_NUM_SIZE-1:0] LAST_IDX = BYTE_NUM_SIZE'(SIZE_IN_BYTES - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                     r_state;
  logic [W-1:0]               r_shadow;
  logic [BYTE_NUM_SIZE-1:0]   r_cnt;
  logic [7:0]                 r_byte;
  logic                       r_last;
  logic                       r_done;

  logic                       w_xfer;
  logic [BYTE_NUM_SIZE-1:0]   w_cnt_nxt;
  logic [W-1:0]               w_shifted;
  logic [7:0]                 w_next_byte;

  assign w_xfer      = (r_state == S_SEND) && OUTPUT_READY;
  assign w_cnt_nxt   = r_cnt + 1'b1;
  // Byte for the next index is pre-selected so OUTPUT_VALUE stays a register.
  // On the final byte this value is unused, so index overflow is harmless.
  assign w_shifted   = r_shadow >> {w_cnt_nxt, 3'b000};
  assign w_next_byte = w_shifted[7:0];

  always_ff @(posedge CLK or negedge ARESET) begin
    if (!ARESET) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_cnt    <= '0;
      r_byte   <= '0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (LOAD) begin
            r_state  <= S_SEND;
            r_shadow <= INPUT_VALUE;
            r_cnt    <= '0;
            r_byte   <= INPUT_VALUE[7:0];
            r_last   <= (LAST_IDX == '0);
          end
        end
        S_SEND: begin
          // LOAD is deliberately not looked at here: no capture, no queueing.
          if (w_xfer) begin
            if (r_cnt == LAST_IDX) begin
              r_state <= S_IDLE;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt  <= w_cnt_nxt;
              r_byte <= w_next_byte;
              r_last <= (w_cnt_nxt == LAST_IDX);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign LOAD_READY   = (r_state == S_IDLE);
  assign OUTPUT_VALID = (r_state == S_SEND);
  assign OUTPUT_VALUE = r_byte;
  assign BYTE_NUM     = r_cnt;
  assign LAST         = r_last;
  assign DONE         = r_done;

endmodule

// File: tb/tb_byte_read_serializer.sv
module tb_byte_read_serializer;

  localparam int N = 13;

  logic         CLK = 1'b0;
  logic         ARESET;
  logic         LOAD;
  logic [103:0] INPUT_VALUE;
  logic         LOAD_READY;
  logic [7:0]   OUTPUT_VALUE;
  logic [3:0]   BYTE_NUM;
  logic         OUTPUT_VALID;
  logic         OUTPUT_READY;
  logic         LAST;
  logic         DONE;

  int checks = 0;
  int errors = 0;

  localparam logic [103:0] W0  = 104'h0C_0B0A_0908_0706_0504_0302_0100;
  localparam logic [103:0] W2  = 104'h3C_1F2E_4D5A_6978_8796_A5B4_C3D2;
  localparam logic [103:0] WA5 = {13{8'hA5}};
  localparam logic [103:0] WFF = {13{8'hFF}};

  byte_read_serializer #(.SIZE_IN_BYTES(N), .BYTE_NUM_SIZE(4)) dut (
    .CLK(CLK), .ARESET(ARESET), .LOAD(LOAD), .INPUT_VALUE(INPUT_VALUE),
    .LOAD_READY(LOAD_READY), .OUTPUT_VALUE(OUTPUT_VALUE), .BYTE_NUM(BYTE_NUM),
    .OUTPUT_VALID(OUTPUT_VALID), .OUTPUT_READY(OUTPUT_READY), .LAST(LAST), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [103:0] w);
    INPUT_VALUE = w;
    LOAD = 1'b1;
    @(posedge CLK); #1;
    LOAD = 1'b0;
  endtask

  // Called #1 after the load edge; walks the frame and checks every byte.
  // mode 0: ready always high; mode 1: ready 1,0,0,1,0,0,...
  task automatic run_frame(input logic [103:0] w, input int mode, input bit ign,
                           input bit load_end, input logic [103:0] nw);
    int idx = 0;
    int k = 0;
    bit rdy;
    logic [103:0] asm_w = '0;
    while (idx < N && k < 200) begin
      check("valid", OUTPUT_VALID, 1);
      check("byte_num", BYTE_NUM, idx);
      check("byte", OUTPUT_VALUE, w[idx*8 +: 8]);
      check("last", LAST, (idx == N-1));
      check("done_mid", DONE, 0);
      check("load_ready_mid", LOAD_READY, 0);
      rdy = (mode == 0) ? 1'b1 : (k % 3 == 0);
      OUTPUT_READY = rdy;
      LOAD = 1'b0;
      if (ign && idx == 5) begin LOAD = 1'b1; INPUT_VALUE = WFF; end
      if (load_end && idx == N-1 && rdy) begin LOAD = 1'b1; INPUT_VALUE = nw; end
      if (rdy && BYTE_NUM < N) asm_w[int'(BYTE_NUM)*8 +: 8] = OUTPUT_VALUE;
      @(posedge CLK); #1;
      if (rdy) idx++;
      k++;
    end
    if (idx < N) check("frame_timeout", idx, N);
    check("done_pulse", DONE, 1);
    check("valid_after", OUTPUT_VALID, 0);
    check("last_after", LAST, 0);
    check("load_ready_after", LOAD_READY, 1);
    check("round_trip", asm_w, w);
  endtask

  initial begin
    ARESET = 1'b0; LOAD = 1'b0; OUTPUT_READY = 1'b0; INPUT_VALUE = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_load_ready", LOAD_READY, 1);
    check("rst_valid", OUTPUT_VALID, 0);
    ARESET = 1'b1;
    @(posedge CLK); #1;
    check("rel_load_ready", LOAD_READY, 1);
    check("rel_valid", OUTPUT_VALID, 0);
    check("rel_value", OUTPUT_VALUE, 0);
    check("rel_byte_num", BYTE_NUM, 0);
    check("rel_last", LAST, 0);
    check("rel_done", DONE, 0);

    // full-rate frame
    load(W0);
    run_frame(W0, 0, 0, 0, '0);
    @(posedge CLK); #1;
    check("done_one_cycle", DONE, 0);
    check("idle_valid", OUTPUT_VALID, 0);

    // backpressure, then back-to-back load at the earliest edge
    load(W0);
    run_frame(W0, 1, 0, 0, '0);
    load(W0);
    // ignored load during byte 5
    run_frame(W0, 0, 1, 0, '0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check("no_second_frame", OUTPUT_VALID, 0);
      check("no_second_done", DONE, 0);
    end

    // LOAD at the final-transfer edge is not taken; held one more edge it is
    load(W0);
    run_frame(W0, 0, 0, 1, W2);
    @(posedge CLK); #1;
    LOAD = 1'b0;
    run_frame(W2, 0, 0, 0, '0);

    // mid-frame reset
    OUTPUT_READY = 1'b1;
    load(W0);
    repeat (7) @(posedge CLK);
    #1;
    check("pre_rst_byte_num", BYTE_NUM, 7);
    check("pre_rst_value", OUTPUT_VALUE, 8'h07);
    #2 ARESET = 1'b0;
    #1;
    check("async_valid", OUTPUT_VALID, 0);
    check("async_load_ready", LOAD_READY, 1);
    check("async_byte_num", BYTE_NUM, 0);
    check("async_value", OUTPUT_VALUE, 0);
    check("async_last", LAST, 0);
    @(posedge CLK); #1;
    check("rst_no_done", DONE, 0);
    ARESET = 1'b1;
    load(WA5);
    run_frame(WA5, 0, 0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
